// File: rtl/complement2_pipe.sv
// Two's-complement PASS/NEG/ABS/NABS unit behind a valid/ready pipeline of
// STAGES registers, with a saturating count of delivered overflowing results.
module complement2_pipe #(
   parameter int N         = 32,
   parameter int STAGES    = 2,
   parameter bit SATURATE  = 1'b0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_data,
   input  logic [1:0]           in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         out_data,
   output logic                 out_overflow,
   output logic [CNT_WIDTH-1:0] ovf_count
);

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_NABS = 2'b11
   } mode_e;

   localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};

   mode_e                mode;
   logic [N-1:0]         negated;
   logic [N-1:0]         result_d;
   logic                 overflow_d;
   logic                 advance;
   logic [N-1:0]         stageData_q  [STAGES];
   logic                 stageOvf_q   [STAGES];
   logic                 stageValid_q [STAGES];
   logic [CNT_WIDTH-1:0] ovfCount_q;
   logic [CNT_WIDTH-1:0] ovfCount_d;

   assign mode    = mode_e'(in_mode);
   assign negated = ~in_data + N'(1);

   always_comb begin
      result_d   = in_data;
      overflow_d = 1'b0;
      case (mode)
         MODE_PASS: result_d = in_data;
         MODE_NEG:  result_d = negated;
         MODE_ABS:  result_d = in_data[N-1] ? negated : in_data;
         MODE_NABS: result_d = in_data[N-1] ? in_data : negated;
         default:   result_d = in_data;
      endcase
      // MIN has no positive counterpart, so only NEG/ABS of MIN can overflow.
      if ((in_data == MIN_VAL) && ((mode == MODE_NEG) || (mode == MODE_ABS))) begin
         overflow_d = 1'b1;
         result_d   = SATURATE ? MAX_POS : MIN_VAL;
      end
   end

   assign advance      = !out_valid || out_ready;
   assign in_ready     = advance;
   assign out_valid    = stageValid_q[STAGES-1];
   assign out_data     = stageData_q[STAGES-1];
   assign out_overflow = stageOvf_q[STAGES-1];
   assign ovf_count    = ovfCount_q;

   // All stages shift together; an idle input cycle becomes a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stageValid_q[i] <= 1'b0;
            stageData_q[i]  <= '0;
            stageOvf_q[i]   <= 1'b0;
         end
      end else if (advance) begin
         stageValid_q[0] <= in_valid;
         stageData_q[0]  <= result_d;
         stageOvf_q[0]   <= overflow_d;
         for (int i = 1; i < STAGES; i++) begin
            stageValid_q[i] <= stageValid_q[i-1];
            stageData_q[i]  <= stageData_q[i-1];
            stageOvf_q[i]   <= stageOvf_q[i-1];
         end
      end
   end

   assign ovfCount_d = (out_valid && out_ready && out_overflow && (ovfCount_q != '1))
                       ? ovfCount_q + CNT_WIDTH'(1) : ovfCount_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovfCount_q <= '0;
      end else begin
         ovfCount_q <= ovfCount_d;
      end
   end

endmodule

// File: tb/tb_complement2_pipe.sv
// Directed bench: wrapping, saturating and 2-bit-counter instances share one
// stimulus stream; results are compared against hand-computed vectors.
module tb_complement2_pipe;

   localparam int N  = 32;
   localparam int NV = 14;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic [N-1:0] inData;
   logic [1:0]  inMode;
   logic        outReady;

   logic        inReady,  outValid,  outOvf;
   logic [N-1:0] outData;
   logic [15:0] ovfCount;
   logic        inReadyS, outValidS, outOvfS;
   logic [N-1:0] outDataS;
   logic [15:0] ovfCountS;
   logic        inReadyC, outValidC, outOvfC;
   logic [N-1:0] outDataC;
   logic [1:0]  ovfCountC;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [1:0]   mode;
      logic [N-1:0] data;
      logic [N-1:0] expWrap;
      logic [N-1:0] expSat;
      logic         expOvf;
   } vec_t;

   vec_t         vecs [NV];
   logic [N-1:0] stallData [4];
   logic [N-1:0] expQ [$];
   int           accepted;
   int           delivered;
   int           stallLeft;

   always #5 clk = ~clk;

   complement2_pipe #(.N(N), .STAGES(2), .SATURATE(1'b0), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
      .in_data(inData), .in_mode(inMode), .out_valid(outValid), .out_ready(outReady),
      .out_data(outData), .out_overflow(outOvf), .ovf_count(ovfCount)
   );

   complement2_pipe #(.N(N), .STAGES(2), .SATURATE(1'b1), .CNT_WIDTH(16)) dutSat (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyS),
      .in_data(inData), .in_mode(inMode), .out_valid(outValidS), .out_ready(outReady),
      .out_data(outDataS), .out_overflow(outOvfS), .ovf_count(ovfCountS)
   );

   complement2_pipe #(.N(N), .STAGES(2), .SATURATE(1'b0), .CNT_WIDTH(2)) dutCnt (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReadyC),
      .in_data(inData), .in_mode(inMode), .out_valid(outValidC), .out_ready(outReady),
      .out_data(outDataC), .out_overflow(outOvfC), .ovf_count(ovfCountC)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [N-1:0] d);
      inValid = v;
      inMode  = m;
      inData  = d;
   endtask

   initial begin
      vecs = '{
         '{2'b01, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0},
         '{2'b01, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
         '{2'b01, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0},
         '{2'b01, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1},
         '{2'b10, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1},
         '{2'b11, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0},
         '{2'b10, 32'hFFFFFFF6, 32'h0000000A, 32'h0000000A, 1'b0},
         '{2'b11, 32'h0000000A, 32'hFFFFFFF6, 32'hFFFFFFF6, 1'b0},
         '{2'b00, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0},
         '{2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0},
         '{2'b10, 32'h00000005, 32'h00000005, 32'h00000005, 1'b0},
         '{2'b11, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'hFFFFFFFB, 1'b0},
         '{2'b01, 32'h7FFFFFFF, 32'h80000001, 32'h80000001, 1'b0},
         '{2'b11, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0}
      };
      stallData = '{32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};

      reset    = 1'b1;
      outReady = 1'b1;
      applyStimulus(1'b0, 2'b00, '0);
      #1;
      checkOutput("rst_out_valid", outValid, 0);
      checkOutput("rst_out_data", outData, 0);
      checkOutput("rst_out_overflow", outOvf, 0);
      checkOutput("rst_ovf_count", ovfCount, 0);
      checkOutput("rst_in_ready", inReady, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Back-to-back table stream; each result appears two edges after acceptance.
      for (int s = 0; s < NV + 2; s++) begin
         @(negedge clk);
         if (s == 1) checkOutput("latency_not_early", outValid, 0);
         if (s >= 2) begin
            checkOutput($sformatf("vec%0d_valid", s-2), outValid, 1);
            checkOutput($sformatf("vec%0d_data", s-2), outData, vecs[s-2].expWrap);
            checkOutput($sformatf("vec%0d_ovf", s-2), outOvf, vecs[s-2].expOvf);
            checkOutput($sformatf("vec%0d_sat_data", s-2), outDataS, vecs[s-2].expSat);
            checkOutput($sformatf("vec%0d_sat_ovf", s-2), outOvfS, vecs[s-2].expOvf);
         end
         if (s < NV) applyStimulus(1'b1, vecs[s].mode, vecs[s].data);
         else        applyStimulus(1'b0, 2'b00, '0);
      end
      @(negedge clk);
      checkOutput("drain_bubble", outValid, 0);
      checkOutput("table_ovf_count", ovfCount, 2);
      checkOutput("table_ovf_count_sat", ovfCountS, 2);
      checkOutput("table_ovf_count_cnt2", ovfCountC, 2);

      // Stall for three cycles once the first result shows up.
      accepted  = 0;
      delivered = 0;
      stallLeft = 3;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (outValid && stallLeft > 0) begin
            outReady = 1'b0;
            stallLeft--;
         end else begin
            outReady = 1'b1;
         end
         if (accepted < 4) applyStimulus(1'b1, 2'b00, stallData[accepted]);
         else              applyStimulus(1'b0, 2'b00, '0);
         #1;
         checkOutput($sformatf("stall_in_ready_c%0d", c), inReady, outReady);
         if (outValid) begin
            if (expQ.size() == 0) begin
               checkOutput($sformatf("stall_spurious_c%0d", c), outValid, 0);
            end else begin
               checkOutput($sformatf("stall_data_c%0d", c), outData, expQ[0]);
               if (outReady) begin
                  void'(expQ.pop_front());
                  delivered++;
               end
            end
         end
         if (inValid && outReady) begin
            expQ.push_back(stallData[accepted]);
            accepted++;
         end
      end
      outReady = 1'b1;
      checkOutput("stall_delivered", delivered, 4);
      checkOutput("stall_idle", outValid, 0);

      // Saturating 2-bit counter: five overflowing NEG(MIN) results.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int s = 0; s < 8; s++) begin
         @(negedge clk);
         if (s == 2) checkOutput("cnt_before_consume", ovfCountC, 0);
         if (s >= 3) begin
            checkOutput($sformatf("cnt2_after_%0d", s-2), ovfCountC, (s-2 > 3) ? 3 : s-2);
            checkOutput($sformatf("cnt16_after_%0d", s-2), ovfCount, s-2);
         end
         if (s < 5) applyStimulus(1'b1, 2'b01, 32'h80000000);
         else       applyStimulus(1'b0, 2'b00, '0);
      end

      // Asynchronous reset in the middle of a stream.
      applyStimulus(1'b1, 2'b01, 32'h80000000);
      repeat (2) @(negedge clk);
      checkOutput("mid_stream_valid", outValid, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_valid", outValid, 0);
      checkOutput("async_rst_data", outData, 0);
      checkOutput("async_rst_count", ovfCount, 0);
      checkOutput("async_rst_count_cnt2", ovfCountC, 0);
      checkOutput("async_rst_in_ready", inReady, 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 2'b00, '0);
      @(negedge clk);
      checkOutput("post_rst_discarded", outValid, 0);
      applyStimulus(1'b1, 2'b11, 32'h00000005);
      @(negedge clk);
      applyStimulus(1'b0, 2'b00, '0);
      checkOutput("post_rst_latency", outValid, 0);
      @(negedge clk);
      checkOutput("post_rst_valid", outValid, 1);
      checkOutput("post_rst_data", outData, 32'hFFFFFFFB);
      checkOutput("post_rst_ovf", outOvf, 0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/complement2_pipe.md
COMPLEMENT2_PIPE -- requirements
Module: complement2_pipe

Interface
REQ-001 SHALL have parameter N, default WORD_WIDTH (32), data width in bits, N >= 2.
REQ-002 SHALL have parameter STAGES, default 2, pipeline register stages, STAGES >= 1.
REQ-003 SHALL have parameter SATURATE, default 0; 1 = clamp overflowing results, 0 = wrap.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, width of overflow event counter.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  upstream operand valid.
REQ-008 SHALL have port in_ready  output  1  block can accept operand this cycle.
REQ-009 SHALL have port in_data  input  N  signed two's-complement operand.
REQ-010 SHALL have port in_mode  input  2  00 PASS, 01 NEG, 10 ABS, 11 NABS.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_data  output  N  result.
REQ-014 SHALL have port out_overflow  output  1  result overflowed (per REQ-019).
REQ-015 SHALL have port ovf_count  output  CNT_WIDTH  count of delivered overflowing results.

Function
REQ-016 SHALL compute, for operand x and MIN = 1 followed by N-1 zeros: PASS -> x; NEG -> ~x+1 mod 2^N; ABS -> x if x[N-1]=0 else ~x+1; NABS -> x if x[N-1]=1 else ~x+1.
REQ-017 SHALL compute result and overflow from in_data/in_mode in the acceptance cycle; later stages only carry data, overflow and valid.
REQ-018 SHALL accept an operand when in_valid && in_ready at a rising clk edge.
REQ-019 SHALL set overflow = 1 only for x == MIN with mode NEG or ABS; PASS, NABS, and all other operands give 0; NEG/NABS of 0 gives 0, no overflow.
REQ-020 SHALL, when overflow and SATURATE=1, output 0 followed by N-1 ones (max positive); when SATURATE=0, output MIN (wrapped).
REQ-021 SHALL advance all stages together when advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-022 SHALL hold every stage (data, overflow, valid) unchanged when advance = 0.
REQ-023 SHALL insert a bubble (valid 0) into stage 1 when advance = 1 and in_valid = 0; bubbles are not collapsed.
REQ-024 SHALL deliver a result accepted at edge k as out_valid = 1 after edge k+STAGES-1, absent stalls: STAGES cycles latency, throughput one per cycle with out_ready held 1.
REQ-025 SHALL keep out_data, out_overflow stable while out_valid && !out_ready.
REQ-026 SHALL preserve order; no result dropped or duplicated.
REQ-027 SHALL increment ovf_count by 1 on each edge with out_valid && out_ready && out_overflow, saturating at all ones (no wrap).
REQ-028 SHALL accept a new operand in the same cycle the last stage is consumed (out_ready = 1 with full pipeline).

Reset
REQ-029 SHALL, on reset assertion, immediately clear all stage valids, out_valid = 0, out_data = 0, out_overflow = 0, ovf_count = 0, independent of clk.
REQ-030 SHALL, while reset = 1, drive in_ready = 1 and accept nothing; in-flight operands at reset are discarded.
REQ-031 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (N=32, STAGES=2, CNT_WIDTH=16 unless stated)
REQ-032 SHALL cover: NEG of 0x00000000, 0x00000001, 0xFFFFFFFF, out_ready=1 -> 0x00000000, 0xFFFFFFFF, 0x00000001, overflow 0, each 2 cycles after acceptance, back-to-back.
REQ-033 SHALL cover: NEG and ABS of 0x80000000, SATURATE=0 -> 0x80000000, overflow 1; SATURATE=1 -> 0x7FFFFFFF, overflow 1; NABS of 0x80000000 -> 0x80000000, overflow 0; ovf_count = 2 after both delivered.
REQ-034 SHALL cover: ABS 0xFFFFFFF6 -> 0x0000000A; NABS 0x0000000A -> 0xFFFFFFF6; PASS 0x12345678 -> 0x12345678.
REQ-035 SHALL cover: stream 4 operands, out_ready=0 for 3 cycles once out_valid -> in_ready=0, out_data held, all 4 delivered in order with no loss.
REQ-036 SHALL cover: CNT_WIDTH=2, deliver 5 overflowing results -> ovf_count 1,2,3,3,3.
REQ-037 SHALL cover: reset asserted mid-stream between clk edges -> out_valid, ovf_count go 0 before next edge; first post-reset operand delivered after 2 cycles with correct value.
